gate_tt_sequencer: RTL and testbench

Self-checking truth-table sequencer for the two-input, seven-output gate block (y1..y7 = AND, OR, NOT a, NAND, NOR, XOR, XNOR).
- Drives a/b through all four input combinations.
- Waits a programmable settle time per combination, then samples the seven outputs.
- Compares each sample against the golden table and reports pass/fail with diagnostics.
- Sits directly upstream (stimulus) and downstream (checker) of the gate block on the board/FPGA bring-up path.

---
 rtl/gate_tt_pkg.sv | 21 ++
 rtl/gate_tt_sequencer_if.sv | 28 ++
 rtl/gate_block.sv | 21 ++
 rtl/gate_tt_top.sv | 41 ++++
 rtl/gate_tt_sequencer.sv | 146 ++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate-block truth-table sequencer: state encoding,
// output bit positions and the golden response table.
package gate_tt_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int NUM_COMBOS = 4;
    localparam int Y_W        = 7;

    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NOTA = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XOR  = 5;
    localparam int Y_XNOR = 6;

    // Expected y for combination k, where a=k[1], b=k[0].
    localparam logic [Y_W-1:0] GOLDEN [0:NUM_COMBOS-1] = '{7'h5C, 7'h2E, 7'h2A, 7'h43};

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Stimulus/response bus between the sequencer and the gate block, plus the
// run control and result signals.
interface gate_tt_sequencer_if;
    import gate_tt_pkg::*;

    logic                  start;
    logic                  a;
    logic                  b;
    logic [Y_W-1:0]        y;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [2:0]            err_count;
    logic [NUM_COMBOS-1:0] fail_mask;
    logic [1:0]            first_fail_idx;
    logic [Y_W-1:0]        first_fail_y;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_count, fail_mask, first_fail_idx, first_fail_y
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_count, fail_mask, first_fail_idx, first_fail_y
    );

endinterface

// File: rtl/gate_block.sv
// Two-input, seven-output combinational gate block exercised by the sequencer.
module gate_block
    import gate_tt_pkg::*;
(
    input  logic           a,
    input  logic           b,
    output logic [Y_W-1:0] y
);

    always_comb begin
        y         = '0;
        y[Y_AND]  = a & b;
        y[Y_OR]   = a | b;
        y[Y_NOTA] = ~a;
        y[Y_NAND] = ~(a & b);
        y[Y_NOR]  = ~(a | b);
        y[Y_XOR]  = a ^ b;
        y[Y_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_tt_top.sv
// Bring-up wrapper: the sequencer driving and checking a real gate block.
module gate_tt_top #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail_idx,
    output logic [6:0] first_fail_y
);

    gate_tt_sequencer_if bus ();

    assign bus.start = start;

    gate_block u_gate (
        .a (bus.a),
        .b (bus.b),
        .y (bus.y)
    );

    gate_tt_sequencer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_seq (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign busy           = bus.busy;
    assign done           = bus.done;
    assign pass           = bus.pass;
    assign err_count      = bus.err_count;
    assign fail_mask      = bus.fail_mask;
    assign first_fail_idx = bus.first_fail_idx;
    assign first_fail_y   = bus.first_fail_y;

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks a/b through all four combinations, samples y after a settle window and
// scores each sample against the golden table.
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    gate_tt_sequencer_if.master bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("gate_tt_sequencer: SETTLE_CYCLES must be in 1..255");
    end
    if (CNT_W < 1 || (CNT_W < 31 && (2 ** CNT_W) <= SETTLE_CYCLES)) begin : g_bad_cnt_w
        $error("gate_tt_sequencer: CNT_W too narrow for SETTLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_COMBOS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic                  a_q, a_d;
    logic                  b_q, b_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [2:0]            err_q, err_d;
    logic [NUM_COMBOS-1:0] fmask_q, fmask_d;
    logic [1:0]            ffi_q, ffi_d;
    logic [Y_W-1:0]        ffy_q, ffy_d;
    logic                  mism;

    // Case inequality lets an undriven/X output score as a mismatch in simulation.
`ifdef SYNTHESIS
    assign mism = (bus.y != GOLDEN[idx_q]);
`else
    assign mism = (bus.y !== GOLDEN[idx_q]);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fmask_d = fmask_q;
        ffi_d   = ffi_q;
        ffy_d   = ffy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fmask_d = '0;
                    ffi_d   = '0;
                    ffy_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (mism) begin
                        fmask_d[idx_q] = 1'b1;
                        err_d          = err_q + 3'd1;
                        if (fmask_q == '0) begin
                            ffi_d = idx_q;
                            ffy_d = bus.y;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (fmask_d == '0);
                    end else begin
                        idx_d = idx_q + 2'd1;
                        a_d   = idx_d[1];
                        b_d   = idx_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fmask_q <= '0;
            ffi_q   <= '0;
            ffy_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fmask_q <= fmask_d;
            ffi_q   <= ffi_d;
            ffy_q   <= ffy_d;
        end
    end

    assign bus.a              = a_q;
    assign bus.b              = b_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_mask      = fmask_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.first_fail_y   = ffy_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Randomized scoreboard bench: two sequencers (settle 2 and 1) see a modelled
// gate block with per-combination fault masks; a reference model predicts each run.
module tb_gate_tt_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    typedef struct {
        int         start_cyc;
        int         done_cyc;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fm;
        logic [1:0] ffi;
        logic [6:0] ffy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   busy_until [2];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [6:0] flip [4];

    // Behavioural gate truth, written from the gate definitions rather than a table.
    function automatic logic [6:0] good_y(input logic a, input logic b);
        logic [6:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = ~a;
        r[3] = ~(a & b);
        r[4] = ~(a | b);
        r[5] = a ^ b;
        r[6] = ~(a ^ b);
        return r;
    endfunction

    gate_tt_sequencer_if if0 ();
    gate_tt_sequencer_if if1 ();
    assign if0.start = start;
    assign if1.start = start;
    assign if0.y = good_y(if0.a, if0.b) ^ flip[{if0.a, if0.b}];
    assign if1.y = good_y(if1.a, if1.b) ^ flip[{if1.a, if1.b}];

    gate_tt_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    gate_tt_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    logic       t_busy, t_done, t_pass;
    logic [2:0] t_err;
    logic [3:0] t_fm;
    logic [1:0] t_ffi;
    logic [6:0] t_ffy;
    gate_tt_top #(.SETTLE_CYCLES(2)) u_top (
        .clk(clk), .rst(rst), .start(start), .busy(t_busy), .done(t_done), .pass(t_pass),
        .err_count(t_err), .fail_mask(t_fm), .first_fail_idx(t_ffi), .first_fail_y(t_ffy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic exp_t predict(input int s);
        exp_t e;
        e.start_cyc = cyc;
        e.done_cyc  = cyc + 4 * (s + 1);
        e.err = '0; e.fm = '0; e.ffi = '0; e.ffy = '0;
        for (int k = 0; k < 4; k++) begin
            if (flip[k] != 7'd0) begin
                if (e.err == 3'd0) begin
                    e.ffi = 2'(k);
                    e.ffy = good_y(k[1], k[0]) ^ flip[k];
                end
                e.fm[k] = 1'b1;
                e.err   = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    // Reference model: decides at each edge which DUT accepts a start.
    initial begin
        busy_until[0] = -1;
        busy_until[1] = -1;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q0.delete();
                q1.delete();
                busy_until[0] = -1;
                busy_until[1] = -1;
            end else if (start) begin
                if (cyc > busy_until[0]) begin
                    q0.push_back(predict(2));
                    busy_until[0] = q0[$].done_cyc;
                end
                if (cyc > busy_until[1]) begin
                    q1.push_back(predict(1));
                    busy_until[1] = q1[$].done_cyc;
                end
            end
        end
    end

    task automatic mon(input int d, input int s, input logic a, input logic b, input logic busy,
                       input logic done, input logic pass, input logic [2:0] err,
                       input logic [3:0] fm, input logic [1:0] ffi, input logic [6:0] ffy);
        exp_t e;
        bit   has;
        bit   eb;
        int   eab;
        has = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (has) e = (d == 0) ? q0[0] : q1[0];
        if (has && cyc == e.start_cyc)
            chk($sformatf("d%0d_cleared", d), {pass, err, fm, ffi, ffy}, 32'd0);
        eb  = has && (cyc < e.done_cyc);
        eab = eb ? (cyc - e.start_cyc) / (s + 1) : 0;
        chk($sformatf("d%0d_busy", d), 32'(busy), 32'(eb));
        chk($sformatf("d%0d_ab", d), 32'({a, b}), eab);
        if (has && cyc == e.done_cyc) begin
            chk($sformatf("d%0d_done", d), 32'(done), 32'd1);
            chk($sformatf("d%0d_pass", d), 32'(pass), 32'(e.pass));
            chk($sformatf("d%0d_err_count", d), 32'(err), 32'(e.err));
            chk($sformatf("d%0d_fail_mask", d), 32'(fm), 32'(e.fm));
            chk($sformatf("d%0d_first_fail_idx", d), 32'(ffi), 32'(e.ffi));
            chk($sformatf("d%0d_first_fail_y", d), 32'(ffy), 32'(e.ffy));
            if (d == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end else if (done) begin
            chk($sformatf("d%0d_unexpected_done", d), 32'(done), 32'd0);
        end
    endtask

    // Monitor samples on the falling edge, away from DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon(0, 2, if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count,
                    if0.fail_mask, if0.first_fail_idx, if0.first_fail_y);
                mon(1, 1, if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_count,
                    if1.fail_mask, if1.first_fail_idx, if1.first_fail_y);
                if (t_done) chk("top_pass", {t_pass, t_err, t_fm}, {1'b1, 3'd0, 4'd0});
            end
        end
    end

    task automatic chk_reset(input string nm);
        chk({nm, "_d0"}, {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count,
                          if0.fail_mask, if0.first_fail_idx, if0.first_fail_y}, 32'd0);
        chk({nm, "_d1"}, {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_count,
                          if1.fail_mask, if1.first_fail_idx, if1.first_fail_y}, 32'd0);
        chk({nm, "_top"}, {t_busy, t_done, t_pass, t_err, t_fm, t_ffi, t_ffy}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        chk("idle_timeout", q0.size() + q1.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic set_flips(input logic [6:0] f0, input logic [6:0] f1,
                             input logic [6:0] f2, input logic [6:0] f3);
        flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        set_flips(7'h00, 7'h00, 7'h00, 7'h00);
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        start = 1'b0;

        // Clean run, then AND stuck-at-0, then XOR/XNOR swapped.
        pulse_start();
        wait_idle();
        set_flips(7'h00, 7'h00, 7'h00, 7'h01);
        pulse_start();
        wait_idle();
        set_flips(7'h60, 7'h60, 7'h60, 7'h60);
        pulse_start();
        wait_idle();

        // Reset mid-run with start low: no done, results cleared, then a clean run.
        set_flips(7'h00, 7'h7F, 7'h00, 7'h00);
        pulse_start();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrun_reset");
        rst = 1'b0;
        set_flips(7'h00, 7'h00, 7'h00, 7'h00);
        pulse_start();
        wait_idle();

        // Start re-pulsed mid-run is ignored.
        set_flips(7'h04, 7'h00, 7'h10, 7'h00);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle();

        // Start held high: back-to-back runs.
        set_flips(7'h00, 7'h02, 7'h00, 7'h00);
        @(negedge clk) start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 4; k++)
                flip[k] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            pulse_start();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                pulse_start();
            end
            wait_idle();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
